sw_piso_reader: RTL and testbench
=================================

Name: sw_piso_reader

Overview:
- Reads an external parallel-in/serial-out switch/button chain (74HC165-style) on the SWORD board.
- Serially shifts the chain, MSB first, and presents the result as a parallel word with a valid strobe and a change strobe.
- It is the input-side counterpart of the serial LED driver: that block clocks data out; this block generates the latch and shift clock and clocks data in.
- Sits between the board pins and user logic, in the Clk_100M domain.

Parameters:
- WIDTH, 16, number of bits in the external chain.
- CLK_DIV, 4, Clk_100M cycles per half-period of ser_clk (>=2).
- SCAN_GAP, 1000, idle Clk_100M cycles between consecutive scans.
- INVERT, 1, when 1 every sampled bit is inverted (board inputs are active-low).

Ports:
- Clk_100M  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-low.
- scan_en  in  1  1 = scan continuously; 0 = stop after the current scan completes.
- ser_di  in  1  serial data from the chain output (QH).
- ser_load_n  out  1  parallel-load strobe to the chain, active low.
- ser_clk  out  1  shift clock to the chain.
- data_out  out  WIDTH  last completed scan; bit WIDTH-1 is the first bit shifted in.
- data_valid  out  1  one-cycle pulse when data_out updates.
- changed  out  1  one-cycle pulse, coincident with data_valid, when the new word differs from the previous one.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is synchronous and active-low on Clk_100M. While reset=0:
  - state=IDLE, ser_load_n=1, ser_clk=0, data_out=0, data_valid=0, changed=0, busy=0, internal shift register=0, previous word=0.
- Tick: a divider counts 0..CLK_DIV-1. The tick fires in the cycle the count equals CLK_DIV-1. The counter clears on entry to LOAD.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE, GAP.
- IDLE: when scan_en=1, go to LOAD next cycle.
- LOAD:
  - ser_load_n=0 and ser_clk=0 for exactly 2 ticks (2*CLK_DIV cycles).
  - Then go to SHIFT_LO with ser_load_n=1 and the bit index = 0.
- SHIFT_LO:
  - ser_clk=0 for 1 tick.
  - In the tick cycle, sample ser_di into shift_reg[0] and shift left (shift_reg <= {shift_reg[WIDTH-2:0], ser_di}). Then go to SHIFT_HI.
- SHIFT_HI:
  - ser_clk=1 for 1 tick (rising edge advances the chain).
  - In the tick cycle, if the bit index = WIDTH-1 go to DONE; otherwise increment the index and go to SHIFT_LO.
- DONE (exactly 1 cycle):
  - ser_clk=0.
  - data_out <= shift_reg XOR {WIDTH{INVERT}}.
  - data_valid=1.
  - changed=1 iff the new value != the current data_out.
  - Then go to GAP.
- GAP:
  - Count SCAN_GAP cycles.
  - Then go to LOAD if scan_en=1, otherwise IDLE.
  - A scan_en change during GAP is evaluated only at the end of GAP.
- scan_en=0 mid-scan: the scan finishes through DONE and GAP, then goes to IDLE. A scan is never truncated.
- Latency: numbering the first LOAD cycle as 0, data_valid is high in cycle 2*CLK_DIV*(WIDTH+1). With the defaults this is cycle 136.
- Scan period with scan_en held at 1: 2*CLK_DIV*(WIDTH+1) + 1 + SCAN_GAP cycles.
- Reset asserted mid-scan aborts the scan with no data_valid. All outputs take their reset values on the next edge.
- ser_di is sampled only in the SHIFT_LO tick cycle. The pin is registered externally by the chain and must be stable for CLK_DIV cycles, so no extra synchroniser is required.
- Outputs are registered; ser_clk and ser_load_n are glitch-free flop outputs.

Decomposition:
- Shared package sword_io_pkg:
  - State encoding constants (IDLE..GAP).
  - Default WIDTH = 16.
  - Board polarity constant INVERT_DEFAULT = 1, also usable by the LED driver.
- One sub-module: clk_tick_div.
  - Parameter DIV; inputs Clk_100M, reset, clr; output tick.
  - Reusable by the LED driver for slowing its shift clock.

Test Plan:
- Chain model loaded with 16'hA5C3, INVERT=0, CLK_DIV=4, scan_en=1 -> data_out=16'hA5C3, data_valid high in cycle 136 after the first LOAD cycle, changed=1, exactly 16 ser_clk rising edges.
- Same chain value, INVERT=1 -> data_out=16'h5A3C; the second consecutive scan gives data_valid=1 with changed=0.
- Chain value changes 16'h0001 -> 16'h8000 during GAP -> next scan gives data_out=16'h8000 with changed=1; the MSB lands in bit 15, confirming MSB-first order.
- scan_en dropped at cycle 50 of a scan -> that scan completes with data_valid at cycle 136; after SCAN_GAP cycles state=IDLE, busy=0, ser_load_n=1, ser_clk=0.
- reset=0 at cycle 80 of a scan -> no data_valid; next edge gives data_out=0, ser_load_n=1, ser_clk=0, busy=0; on release with scan_en=1 a full new scan gives the correct word.
- Timing check with CLK_DIV=2, WIDTH=8 -> ser_load_n low for exactly 4 cycles, ser_clk period 4 cycles, data_valid in cycle 36.

Source files
------------

// File: rtl/sword_io_pkg.sv
// Shared definitions for the SWORD board serial I/O blocks (switch reader,
// LED driver): scan state encoding, default chain width and pin polarity.
package sword_io_pkg;

   // Scan sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_SHIFT_LO = 3'd2,
      ST_SHIFT_HI = 3'd3,
      ST_DONE     = 3'd4,
      ST_GAP      = 3'd5
   } piso_state_t;

   // Default number of bits in the external chain.
   localparam int WIDTH_DEFAULT = 16;

   // Board switches and buttons pull low when active.
   localparam bit INVERT_DEFAULT = 1'b1;

endpackage

// File: rtl/sw_piso_reader_if.sv
// Pin-side and user-side signals of the serial switch reader.
// master = the reader itself, slave = the board/user side.
interface sw_piso_reader_if
   import sword_io_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);
   logic             scan_en;
   logic             ser_di;
   logic             ser_load_n;
   logic             ser_clk;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             changed;
   logic             busy;

   modport master (
      input  scan_en,
      input  ser_di,
      output ser_load_n,
      output ser_clk,
      output data_out,
      output data_valid,
      output changed,
      output busy
   );

   modport slave (
      output scan_en,
      output ser_di,
      input  ser_load_n,
      input  ser_clk,
      input  data_out,
      input  data_valid,
      input  changed,
      input  busy
   );
endinterface

// File: rtl/clk_tick_div.sv
// Free-running 0..DIV-1 divider producing a one-cycle tick on the last count.
// clr restarts the count at 0 so a phase can be aligned to an external event.
module clk_tick_div #(
   parameter int DIV = 4
) (
   input  logic Clk_100M,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Divider count: wraps at DIV-1, restarts on clr.
   always_ff @(posedge Clk_100M) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/sw_piso_reader.sv
// Reads a 74HC165-style switch chain: latches it, shifts it in MSB first and
// presents the word with a valid strobe and a changed strobe.
module sw_piso_reader
   import sword_io_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEFAULT,
   parameter int CLK_DIV  = 4,
   parameter int SCAN_GAP = 1000,
   parameter bit INVERT   = INVERT_DEFAULT
) (
   input logic Clk_100M,
   input logic reset,
   sw_piso_reader_if.master bus
);
   localparam int               IW       = $clog2(WIDTH);
   localparam int               GW       = $clog2(SCAN_GAP + 1);
   localparam logic [WIDTH-1:0] INV_MASK = INVERT ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   piso_state_t      r_state, w_state_nxt;
   logic [IW-1:0]    r_bit_idx, w_bit_idx_nxt;
   logic             r_load_half, w_load_half_nxt;
   logic [GW-1:0]    r_gap_cnt, w_gap_cnt_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic             w_tick;
   logic             w_div_clr;
   logic [WIDTH-1:0] w_word;

   logic             r_load_n;
   logic             r_ser_clk;
   logic [WIDTH-1:0] r_data_out;
   logic             r_valid;
   logic             r_changed;
   logic             r_busy;

   clk_tick_div #(.DIV(CLK_DIV)) u_div (
      .Clk_100M (Clk_100M),
      .reset    (reset),
      .clr      (w_div_clr),
      .tick     (w_tick)
   );

   assign w_word = r_shift ^ INV_MASK;

   // Sequencer state and datapath registers.
   always_ff @(posedge Clk_100M) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_bit_idx   <= '0;
         r_load_half <= 1'b0;
         r_gap_cnt   <= '0;
         r_shift     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_load_half <= w_load_half_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
         r_shift     <= w_shift_nxt;
      end
   end

   // Next-state logic; the divider is realigned whenever a LOAD begins.
   always_comb begin
      w_state_nxt     = r_state;
      w_bit_idx_nxt   = r_bit_idx;
      w_load_half_nxt = r_load_half;
      w_gap_cnt_nxt   = r_gap_cnt;
      w_shift_nxt     = r_shift;
      w_div_clr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.scan_en) begin
               w_state_nxt     = ST_LOAD;
               w_load_half_nxt = 1'b0;
               w_div_clr       = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (w_tick) begin
               if (r_load_half) begin
                  w_state_nxt   = ST_SHIFT_LO;
                  w_bit_idx_nxt = '0;
               end else begin
                  w_load_half_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_SHIFT_LO: begin
            if (w_tick) begin
               w_shift_nxt = {r_shift[WIDTH-2:0], bus.ser_di};
               w_state_nxt = ST_SHIFT_HI;
            end else begin
               w_state_nxt = ST_SHIFT_LO;
            end
         end
         ST_SHIFT_HI: begin
            if (w_tick) begin
               if (r_bit_idx == IW'(WIDTH - 1)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + IW'(1);
                  w_state_nxt   = ST_SHIFT_LO;
               end
            end else begin
               w_state_nxt = ST_SHIFT_HI;
            end
         end
         ST_DONE: begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = '0;
         end
         ST_GAP: begin
            if (r_gap_cnt == GW'(SCAN_GAP - 1)) begin
               if (bus.scan_en) begin
                  w_state_nxt     = ST_LOAD;
                  w_load_half_nxt = 1'b0;
                  w_div_clr       = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + GW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output flops decoded from the next state so pins change with the state.
   always_ff @(posedge Clk_100M) begin
      if (!reset) begin
         r_load_n   <= 1'b1;
         r_ser_clk  <= 1'b0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_changed  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_load_n  <= (w_state_nxt != ST_LOAD);
         r_ser_clk <= (w_state_nxt == ST_SHIFT_HI);
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_valid   <= (w_state_nxt == ST_DONE);
         if (w_state_nxt == ST_DONE) begin
            r_data_out <= w_word;
            r_changed  <= (w_word != r_data_out);
         end else begin
            r_changed  <= 1'b0;
         end
      end
   end

   assign bus.ser_load_n = r_load_n;
   assign bus.ser_clk    = r_ser_clk;
   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_valid;
   assign bus.changed    = r_changed;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_sw_piso_reader.sv
// Scoreboard bench for sw_piso_reader: three instances (non-inverting 16-bit,
// inverting 16-bit, fast 8-bit) driven by behavioural 74HC165 chain models.
module tb_sw_piso_reader;
   localparam int GAP = 30;

   logic Clk_100M = 1'b0;
   logic reset    = 1'b0;
   always #5 Clk_100M = ~Clk_100M;

   sw_piso_reader_if #(.WIDTH(16)) if0 ();
   sw_piso_reader_if #(.WIDTH(16)) if1 ();
   sw_piso_reader_if #(.WIDTH(8))  if2 ();

   sw_piso_reader #(.WIDTH(16), .CLK_DIV(4), .SCAN_GAP(GAP), .INVERT(1'b0))
      u_dut0 (.Clk_100M(Clk_100M), .reset(reset), .bus(if0));
   sw_piso_reader #(.WIDTH(16), .CLK_DIV(4), .SCAN_GAP(GAP), .INVERT(1'b1))
      u_dut1 (.Clk_100M(Clk_100M), .reset(reset), .bus(if1));
   sw_piso_reader #(.WIDTH(8), .CLK_DIV(2), .SCAN_GAP(GAP), .INVERT(1'b0))
      u_dut2 (.Clk_100M(Clk_100M), .reset(reset), .bus(if2));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge Clk_100M) cyc <= cyc + 1;

   // Chain models: parallel load while load_n low, shift on ser_clk rise.
   logic [15:0] pval0 = 16'h0000, pval1 = 16'h0000, ch0 = 16'h0000, ch1 = 16'h0000;
   logic [7:0]  pval2 = 8'h00, ch2 = 8'h00;
   logic        sd0 = 1'b0, sd1 = 1'b0, sd2 = 1'b0;

   always @(posedge Clk_100M) begin
      if (!if0.ser_load_n) ch0 <= pval0;
      else if (if0.ser_clk && !sd0) ch0 <= {ch0[14:0], 1'b0};
      sd0 <= if0.ser_clk;
      if (!if1.ser_load_n) ch1 <= pval1;
      else if (if1.ser_clk && !sd1) ch1 <= {ch1[14:0], 1'b0};
      sd1 <= if1.ser_clk;
      if (!if2.ser_load_n) ch2 <= pval2;
      else if (if2.ser_clk && !sd2) ch2 <= {ch2[6:0], 1'b0};
      sd2 <= if2.ser_clk;
   end
   assign if0.ser_di = ch0[15];
   assign if1.ser_di = ch1[15];
   assign if2.ser_di = ch2[7];

   typedef struct {
      int          id;
      logic [15:0] data;
      logic        chg;
      int          lat;
      int          edges;
   } exp_t;
   exp_t sb[$];

   int   load_start [3];
   int   edges      [3];
   logic ln_prev    [3];
   logic sc_prev    [3];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic mon(input int id, input logic ln, input logic sc, input logic dv,
                      input logic [15:0] d, input logic chg);
      exp_t e;
      if (ln_prev[id] && !ln) begin
         load_start[id] = cyc;
         edges[id]      = 0;
      end
      if (sc && !sc_prev[id]) edges[id]++;
      ln_prev[id] = ln;
      sc_prev[id] = sc;
      if (dv) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid dut%0d actual=%h required=none", id, d);
         end else begin
            e = sb.pop_front();
            chk("sb_dut_id", id, e.id);
            chk("sb_data", int'(d), int'(e.data));
            chk("sb_changed", int'(chg), int'(e.chg));
            chk("sb_latency", cyc - load_start[id], e.lat);
            chk("sb_clk_edges", edges[id], e.edges);
         end
      end
   endtask

   // Monitor: sample all instances away from the active edge.
   always @(negedge Clk_100M) begin
      mon(0, if0.ser_load_n, if0.ser_clk, if0.data_valid, if0.data_out, if0.changed);
      mon(1, if1.ser_load_n, if1.ser_clk, if1.data_valid, if1.data_out, if1.changed);
      mon(2, if2.ser_load_n, if2.ser_clk, if2.data_valid, {8'h00, if2.data_out}, if2.changed);
   end

   function automatic logic busy_of(input int id);
      case (id)
         0:       return if0.busy;
         1:       return if1.busy;
         default: return if2.busy;
      endcase
   endfunction

   function automatic logic load_n_of(input int id);
      case (id)
         0:       return if0.ser_load_n;
         1:       return if1.ser_load_n;
         default: return if2.ser_load_n;
      endcase
   endfunction

   task automatic wait_sb(input int n, input string nm);
      int k = 0;
      while (sb.size() > n && k < 3000) begin
         @(posedge Clk_100M);
         k++;
      end
      #1;
      if (sb.size() > n) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout actual_queue=%0d required<=%0d", nm, sb.size(), n);
      end
   endtask

   task automatic wait_idle(input int id);
      int k = 0;
      while (busy_of(id) && k < 3000) begin
         @(posedge Clk_100M);
         #1;
         k++;
      end
      chk("wait_idle", int'(busy_of(id)), 0);
   endtask

   task automatic wait_load(input int id);
      int k = 0;
      while (load_n_of(id) && k < 3000) begin
         @(posedge Clk_100M);
         #1;
         k++;
      end
      chk("wait_load", int'(load_n_of(id)), 0);
   endtask

   task automatic wait_sclk2(input logic v);
      int k = 0;
      while (if2.ser_clk != v && k < 200) begin
         @(posedge Clk_100M);
         #1;
         k++;
      end
      chk("wait_ser_clk", int'(if2.ser_clk), int'(v));
   endtask

   initial begin
      int k;
      int t_a;
      for (int i = 0; i < 3; i++) begin
         ln_prev[i]    = 1'b1;
         sc_prev[i]    = 1'b0;
         load_start[i] = 0;
         edges[i]      = 0;
      end
      if0.scan_en = 1'b0;
      if1.scan_en = 1'b0;
      if2.scan_en = 1'b0;

      // Reset values.
      reset = 1'b0;
      repeat (3) @(posedge Clk_100M);
      #1;
      chk("rst_data_out", int'(if0.data_out), 0);
      chk("rst_load_n", int'(if0.ser_load_n), 1);
      chk("rst_ser_clk", int'(if0.ser_clk), 0);
      chk("rst_busy", int'(if0.busy), 0);
      chk("rst_valid", int'(if0.data_valid), 0);
      chk("rst_changed", int'(if0.changed), 0);
      chk("rst_busy2", int'(if2.busy), 0);
      reset = 1'b1;

      // Plain scan, no inversion.
      pval0 = 16'hA5C3;
      sb.push_back('{0, 16'hA5C3, 1'b1, 136, 16});
      if0.scan_en = 1'b1;
      wait_sb(0, "t1_scan");
      if0.scan_en = 1'b0;
      wait_idle(0);

      // Inverted scan twice: second scan reports no change.
      pval1 = 16'hA5C3;
      sb.push_back('{1, 16'h5A3C, 1'b1, 136, 16});
      sb.push_back('{1, 16'h5A3C, 1'b0, 136, 16});
      if1.scan_en = 1'b1;
      wait_sb(0, "t2_scan");
      if1.scan_en = 1'b0;
      wait_idle(1);

      // Chain changes during GAP; MSB-first lands in bit 15.
      pval0 = 16'h0001;
      sb.push_back('{0, 16'h0001, 1'b1, 136, 16});
      sb.push_back('{0, 16'h8000, 1'b1, 136, 16});
      if0.scan_en = 1'b1;
      wait_sb(1, "t3_first");
      pval0 = 16'h8000;
      wait_sb(0, "t3_second");
      if0.scan_en = 1'b0;
      wait_idle(0);

      // scan_en dropped mid-scan: scan completes, then idles.
      pval0 = 16'h1234;
      sb.push_back('{0, 16'h1234, 1'b1, 136, 16});
      if0.scan_en = 1'b1;
      wait_load(0);
      repeat (50) @(posedge Clk_100M);
      #1;
      if0.scan_en = 1'b0;
      wait_sb(0, "t4_scan");
      repeat (GAP + 3) @(posedge Clk_100M);
      #1;
      chk("t4_busy", int'(if0.busy), 0);
      chk("t4_load_n", int'(if0.ser_load_n), 1);
      chk("t4_ser_clk", int'(if0.ser_clk), 0);
      chk("t4_data_held", int'(if0.data_out), 16'h1234);

      // Reset mid-scan aborts, then a full scan after release.
      pval0 = 16'h0F0F;
      if0.scan_en = 1'b1;
      wait_load(0);
      repeat (80) @(posedge Clk_100M);
      #1;
      reset = 1'b0;
      @(posedge Clk_100M);
      #1;
      chk("t5_data_out", int'(if0.data_out), 0);
      chk("t5_load_n", int'(if0.ser_load_n), 1);
      chk("t5_ser_clk", int'(if0.ser_clk), 0);
      chk("t5_busy", int'(if0.busy), 0);
      chk("t5_valid", int'(if0.data_valid), 0);
      sb.push_back('{0, 16'h0F0F, 1'b1, 136, 16});
      reset = 1'b1;
      wait_sb(0, "t5_scan");
      if0.scan_en = 1'b0;
      wait_idle(0);

      // Fast 8-bit instance: load width, ser_clk period, latency.
      pval2 = 8'h96;
      sb.push_back('{2, 16'h0096, 1'b1, 36, 8});
      if2.scan_en = 1'b1;
      wait_load(2);
      k = 0;
      while (!if2.ser_load_n && k < 100) begin
         k++;
         @(posedge Clk_100M);
         #1;
      end
      chk("t6_load_width", k, 4);
      wait_sclk2(1'b1);
      t_a = cyc;
      wait_sclk2(1'b0);
      wait_sclk2(1'b1);
      chk("t6_clk_period", cyc - t_a, 4);
      wait_sb(0, "t6_scan");
      if2.scan_en = 1'b0;
      wait_idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
